// File: rtl/nucleo_pkg.sv
// Shared types for the multi-cycle core: FSM states and decoded operations.
// The ISA is total, so every instruction byte decodes to exactly one operation.
package nucleo_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} estado_t;

    typedef enum logic [2:0] {
        OP_BEQ, OP_ADD, OP_SUBI, OP_LOAD, OP_STORE, OP_JUMP, OP_HALT
    } opcode_t;

    localparam logic [1:0] CLS_BEQ  = 2'b00;
    localparam logic [1:0] CLS_ADD  = 2'b01;
    localparam logic [1:0] CLS_SUBI = 2'b10;

    localparam logic [1:0] EXT_LOAD  = 2'b00;
    localparam logic [1:0] EXT_STORE = 2'b01;
    localparam logic [1:0] EXT_JUMP  = 2'b10;

    function automatic opcode_t decodifica(input logic [7:0] ir);
        opcode_t op;
        case (ir[7:6])
            CLS_BEQ:  op = OP_BEQ;
            CLS_ADD:  op = OP_ADD;
            CLS_SUBI: op = OP_SUBI;
            default: begin
                case (ir[5:4])
                    EXT_LOAD:  op = OP_LOAD;
                    EXT_STORE: op = OP_STORE;
                    EXT_JUMP:  op = OP_JUMP;
                    default:   op = OP_HALT;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/banco_registradores_param.sv
// 8-entry register file, DATA_W wide: two asynchronous reads, one synchronous write,
// synchronous reset clearing every entry.
module banco_registradores_param #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [8];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/nucleo_multiciclo.sv
// Multi-cycle core: FETCH/DECODE/EXEC/(MEM)/WB sequencing over handshaked instruction
// and data memories. ALU, branch compare and PC adder live inline here.
module nucleo_multiciclo
    import nucleo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned DADDR_W  = 8,
    parameter int unsigned BR_REG   = 3,
    parameter int unsigned ADDR_REG = 6
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [7:0]         imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ready,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               retire,
    output logic               halted,
    output logic [PC_W-1:0]    dbg_pc
);

    estado_t           estado_q;
    logic [7:0]        ir_q;
    logic [PC_W-1:0]   pc_q, pc_next_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              wb_en_q;
    logic              imem_req_q, dmem_req_q, dmem_we_q, retire_q, halted_q;

    opcode_t           op;
    logic [2:0]        raddr_a, raddr_b, waddr;
    logic [DATA_W-1:0] rdata_a, rdata_b, alu_res;
    logic [PC_W-1:0]   desvio, alvo;
    logic              rf_we;

    assign op = decodifica(ir_q);

    // Port A doubles as the BEQ offset read during EXEC, after A/B are already latched.
    always_comb begin
        raddr_a = ir_q[5:3];
        raddr_b = ir_q[2:0];
        if (op == OP_STORE || op == OP_JUMP) begin
            raddr_a = ir_q[2:0];
        end
        if (op == OP_LOAD || op == OP_STORE) begin
            raddr_b = 3'(ADDR_REG);
        end
        if (estado_q == EXEC) begin
            raddr_a = 3'(BR_REG);
        end
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUBI: alu_res = a_q - DATA_W'(ir_q[2:0]);
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        desvio = '0;
        if (op == OP_BEQ && a_q == b_q) begin
            desvio = PC_W'(rdata_a);
        end
        if (op == OP_JUMP) begin
            desvio = PC_W'(a_q);
        end
        alvo = pc_q + PC_W'(1) + desvio;
    end

    assign waddr = (op == OP_LOAD) ? ir_q[2:0] : ir_q[5:3];
    assign rf_we = (estado_q == WB) && wb_en_q;

    banco_registradores_param #(
        .DATA_W (DATA_W)
    ) u_banco (
        .clock   (clock),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (waddr),
        .wdata   (res_q),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= FETCH;
            pc_q       <= '0;
            pc_next_q  <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            wb_en_q    <= 1'b0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            retire_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (estado_q)
                FETCH: begin
                    if (imem_ready) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        estado_q   <= DECODE;
                    end
                end
                DECODE: begin
                    a_q      <= rdata_a;
                    b_q      <= rdata_b;
                    estado_q <= EXEC;
                end
                EXEC: begin
                    res_q     <= alu_res;
                    pc_next_q <= alvo;
                    wb_en_q   <= (op == OP_ADD) || (op == OP_SUBI) || (op == OP_LOAD);
                    case (op)
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            estado_q <= HALT;
                        end
                        OP_LOAD, OP_STORE: begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (op == OP_STORE);
                            estado_q   <= MEM;
                        end
                        default: begin
                            retire_q <= 1'b1;
                            estado_q <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_ready) begin
                        if (!dmem_we_q) begin
                            res_q <= dmem_rdata;
                        end
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        retire_q   <= 1'b1;
                        estado_q   <= WB;
                    end
                end
                WB: begin
                    pc_q       <= pc_next_q;
                    retire_q   <= 1'b0;
                    imem_req_q <= 1'b1;
                    estado_q   <= FETCH;
                end
                HALT: begin
                    estado_q <= HALT;
                end
                default: begin
                    estado_q <= FETCH;
                end
            endcase
        end
    end

    // Masking with reset keeps every strobe quiet in the reset cycle itself.
    assign imem_req   = imem_req_q & ~reset;
    assign dmem_req   = dmem_req_q & ~reset;
    assign dmem_we    = dmem_we_q & ~reset;
    assign retire     = retire_q & ~reset;
    assign halted     = halted_q & ~reset;
    assign imem_addr  = pc_q;
    assign dbg_pc     = pc_q;
    assign dmem_addr  = b_q[DADDR_W-1:0];
    assign dmem_wdata = a_q;

endmodule
